// File: rtl/mar_scan_unit_if.sv
// Bus bundle for mar_scan_unit: address/scan commands in, address and scan status out.
// The master drives commands; the slave is the address unit itself.
interface mar_scan_unit_if #(
    parameter int ADDR_W = 16,
    parameter int DIM_W  = 10
);
    logic [ADDR_W-1:0] reg_input;
    logic              reg_load;
    logic              reg_inc;
    logic              reg_dec;
    logic              scan_start;
    logic [DIM_W-1:0]  img_width;
    logic [DIM_W-1:0]  img_height;
    logic [ADDR_W-1:0] img_pitch;
    logic              step_en;
    logic [ADDR_W-1:0] MAR_address;
    logic [ADDR_W-1:0] RAM_address;
    logic [DIM_W-1:0]  col;
    logic [DIM_W-1:0]  row;
    logic              scan_busy;
    logic              scan_done;
    logic              end_of_row;

    modport master (
        output reg_input, reg_load, reg_inc, reg_dec, scan_start,
               img_width, img_height, img_pitch, step_en,
        input  MAR_address, RAM_address, col, row, scan_busy, scan_done, end_of_row
    );

    modport slave (
        input  reg_input, reg_load, reg_inc, reg_dec, scan_start,
               img_width, img_height, img_pitch, step_en,
        output MAR_address, RAM_address, col, row, scan_busy, scan_done, end_of_row
    );
endinterface

// File: rtl/mar_scan_unit.sv
// Memory-address register with load/inc/dec and a 2-D raster-scan walker
// (width x height window, programmable row pitch, one pixel per step_en).
module mar_scan_unit #(
    parameter int ADDR_W = 16,
    parameter int DIM_W  = 10
) (
    input  logic            Clk,
    input  logic            Rst,
    mar_scan_unit_if.slave  bus
);
    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [DIM_W-1:0]  DIM_ONE  = {{(DIM_W-1){1'b0}}, 1'b1};
    localparam logic [DIM_W-1:0]  DIM_ZERO = {DIM_W{1'b0}};

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] mar_q, mar_d;
    logic [ADDR_W-1:0] row_base_q, row_base_d;
    logic [ADDR_W-1:0] pitch_q, pitch_d;
    logic [DIM_W-1:0]  width_q, width_d;
    logic [DIM_W-1:0]  height_q, height_d;
    logic [DIM_W-1:0]  col_q, col_d;
    logic [DIM_W-1:0]  row_q, row_d;
    logic              done_q, done_d;

    logic do_load_s, do_start_s, do_step_s, do_inc_s, do_dec_s;
    logic start_empty_s, col_last_s, row_last_s;

    // Command decode with fixed priority: load > start > step > inc > dec.
    assign do_load_s     = bus.reg_load;
    assign do_start_s    = !bus.reg_load && bus.scan_start;
    assign do_step_s     = !bus.reg_load && !bus.scan_start && (state_q == ST_SCAN) && bus.step_en;
    assign do_inc_s      = !bus.reg_load && !bus.scan_start && (state_q == ST_IDLE) && bus.reg_inc;
    assign do_dec_s      = !bus.reg_load && !bus.scan_start && (state_q == ST_IDLE) && !bus.reg_inc
                           && bus.reg_dec;
    assign start_empty_s = (bus.img_width == DIM_ZERO) || (bus.img_height == DIM_ZERO);
    assign col_last_s    = (col_q == (width_q - DIM_ONE));
    assign row_last_s    = (row_q == (height_q - DIM_ONE));

    // State and datapath registers.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q    <= ST_IDLE;
            mar_q      <= {ADDR_W{1'b0}};
            row_base_q <= {ADDR_W{1'b0}};
            pitch_q    <= {ADDR_W{1'b0}};
            width_q    <= DIM_ZERO;
            height_q   <= DIM_ZERO;
            col_q      <= DIM_ZERO;
            row_q      <= DIM_ZERO;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mar_q      <= mar_d;
            row_base_q <= row_base_d;
            pitch_q    <= pitch_d;
            width_q    <= width_d;
            height_q   <= height_d;
            col_q      <= col_d;
            row_q      <= row_d;
            done_q     <= done_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        if (do_load_s) begin
            state_d = ST_IDLE;
        end else if (do_start_s) begin
            state_d = start_empty_s ? ST_IDLE : ST_SCAN;
        end else if (do_step_s && col_last_s && row_last_s) begin
            state_d = ST_IDLE;
        end else begin
            state_d = state_q;
        end
    end

    // Datapath next values; a zero-sized scan completes immediately.
    always_comb begin
        mar_d      = mar_q;
        row_base_d = row_base_q;
        pitch_d    = pitch_q;
        width_d    = width_q;
        height_d   = height_q;
        col_d      = col_q;
        row_d      = row_q;
        done_d     = 1'b0;
        if (do_load_s) begin
            mar_d = bus.reg_input;
        end else if (do_start_s) begin
            width_d    = bus.img_width;
            height_d   = bus.img_height;
            pitch_d    = bus.img_pitch;
            mar_d      = bus.reg_input;
            row_base_d = bus.reg_input;
            col_d      = DIM_ZERO;
            row_d      = DIM_ZERO;
            done_d     = start_empty_s;
        end else if (do_step_s) begin
            if (!col_last_s) begin
                col_d = col_q + DIM_ONE;
                mar_d = mar_q + ADDR_ONE;
            end else if (!row_last_s) begin
                col_d      = DIM_ZERO;
                row_d      = row_q + DIM_ONE;
                row_base_d = row_base_q + pitch_q;
                mar_d      = row_base_q + pitch_q;
            end else begin
                done_d = 1'b1;
            end
        end else if (do_inc_s) begin
            mar_d = mar_q + ADDR_ONE;
        end else if (do_dec_s) begin
            mar_d = mar_q - ADDR_ONE;
        end else begin
            mar_d = mar_q;
        end
    end

    assign bus.MAR_address = mar_q;
    assign bus.RAM_address = mar_q;
    assign bus.col         = col_q;
    assign bus.row         = row_q;
    assign bus.scan_busy   = (state_q == ST_SCAN);
    assign bus.scan_done   = done_q;
    assign bus.end_of_row  = (state_q == ST_SCAN) && col_last_s;
endmodule

// File: tb/tb_mar_scan_unit.sv
// Directed, table-driven bench for mar_scan_unit plus a mid-scan async reset sequence.
module tb_mar_scan_unit;
    logic Clk;
    logic Rst;

    mar_scan_unit_if #(.ADDR_W(16), .DIM_W(10)) bus ();

    mar_scan_unit #(.ADDR_W(16), .DIM_W(10)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct packed {
        logic        ld;
        logic        inc;
        logic        dec;
        logic        st;
        logic        step;
        logic [15:0] din;
        logic [9:0]  w;
        logic [9:0]  h;
        logic [15:0] pitch;
        logic [15:0] e_addr;
        logic [9:0]  e_col;
        logic [9:0]  e_row;
        logic        e_busy;
        logic        e_done;
        logic        e_eor;
    } vec_t;

    vec_t vq[$];
    int   pass_cnt = 0;
    int   check_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        check_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic drive(input vec_t v);
        bus.reg_load   = v.ld;
        bus.reg_inc    = v.inc;
        bus.reg_dec    = v.dec;
        bus.scan_start = v.st;
        bus.step_en    = v.step;
        bus.reg_input  = v.din;
        bus.img_width  = v.w;
        bus.img_height = v.h;
        bus.img_pitch  = v.pitch;
    endtask

    task automatic check_all(input string tag, input logic [15:0] a, input logic [9:0] c,
                             input logic [9:0] r, input logic b, input logic d, input logic e);
        chk({tag, "_addr"}, 32'(bus.MAR_address), 32'(a));
        chk({tag, "_ram"},  32'(bus.RAM_address), 32'(a));
        chk({tag, "_col"},  32'(bus.col), 32'(c));
        chk({tag, "_row"},  32'(bus.row), 32'(r));
        chk({tag, "_busy"}, 32'(bus.scan_busy), 32'(b));
        chk({tag, "_done"}, 32'(bus.scan_done), 32'(d));
        chk({tag, "_eor"},  32'(bus.end_of_row), 32'(e));
    endtask

    vec_t idle_v;

    initial begin
        idle_v = '0;
        //        ld   inc  dec  st   step din       w      h      pitch     addr      col    row    busy done eor
        vq.push_back('{1'b1,1'b0,1'b0,1'b0,1'b0,16'h00FF,10'd0,10'd0,16'h0000,16'h00FF,10'd0,10'd0,1'b0,1'b0,1'b0});
        vq.push_back('{1'b0,1'b1,1'b0,1'b0,1'b0,16'h0000,10'd0,10'd0,16'h0000,16'h0100,10'd0,10'd0,1'b0,1'b0,1'b0});
        vq.push_back('{1'b0,1'b0,1'b1,1'b0,1'b0,16'h0000,10'd0,10'd0,16'h0000,16'h00FF,10'd0,10'd0,1'b0,1'b0,1'b0});
        vq.push_back('{1'b0,1'b0,1'b1,1'b0,1'b0,16'h0000,10'd0,10'd0,16'h0000,16'h00FE,10'd0,10'd0,1'b0,1'b0,1'b0});
        vq.push_back('{1'b1,1'b0,1'b0,1'b0,1'b0,16'hFFFF,10'd0,10'd0,16'h0000,16'hFFFF,10'd0,10'd0,1'b0,1'b0,1'b0});
        vq.push_back('{1'b0,1'b1,1'b0,1'b0,1'b0,16'h0000,10'd0,10'd0,16'h0000,16'h0000,10'd0,10'd0,1'b0,1'b0,1'b0});
        vq.push_back('{1'b0,1'b0,1'b1,1'b0,1'b0,16'h0000,10'd0,10'd0,16'h0000,16'hFFFF,10'd0,10'd0,1'b0,1'b0,1'b0});
        vq.push_back('{1'b1,1'b1,1'b0,1'b0,1'b0,16'h1234,10'd0,10'd0,16'h0000,16'h1234,10'd0,10'd0,1'b0,1'b0,1'b0});
        vq.push_back('{1'b0,1'b0,1'b0,1'b0,1'b1,16'h0000,10'd0,10'd0,16'h0000,16'h1234,10'd0,10'd0,1'b0,1'b0,1'b0});
        // 3x2 raster at 0x1000, pitch 0x40
        vq.push_back('{1'b0,1'b0,1'b0,1'b1,1'b0,16'h1000,10'd3,10'd2,16'h0040,16'h1000,10'd0,10'd0,1'b1,1'b0,1'b0});
        vq.push_back('{1'b0,1'b0,1'b0,1'b0,1'b1,16'h0000,10'd0,10'd0,16'h0000,16'h1001,10'd1,10'd0,1'b1,1'b0,1'b0});
        vq.push_back('{1'b0,1'b0,1'b0,1'b0,1'b1,16'h0000,10'd0,10'd0,16'h0000,16'h1002,10'd2,10'd0,1'b1,1'b0,1'b1});
        vq.push_back('{1'b0,1'b0,1'b0,1'b0,1'b1,16'h0000,10'd0,10'd0,16'h0000,16'h1040,10'd0,10'd1,1'b1,1'b0,1'b0});
        vq.push_back('{1'b0,1'b0,1'b0,1'b0,1'b1,16'h0000,10'd0,10'd0,16'h0000,16'h1041,10'd1,10'd1,1'b1,1'b0,1'b0});
        vq.push_back('{1'b0,1'b0,1'b0,1'b0,1'b1,16'h0000,10'd0,10'd0,16'h0000,16'h1042,10'd2,10'd1,1'b1,1'b0,1'b1});
        vq.push_back('{1'b0,1'b0,1'b0,1'b0,1'b1,16'h0000,10'd0,10'd0,16'h0000,16'h1042,10'd2,10'd1,1'b0,1'b1,1'b0});
        vq.push_back('{1'b0,1'b0,1'b0,1'b0,1'b1,16'h0000,10'd0,10'd0,16'h0000,16'h1042,10'd2,10'd1,1'b0,1'b0,1'b0});
        // degenerate scan: width 0
        vq.push_back('{1'b0,1'b0,1'b0,1'b1,1'b0,16'h0500,10'd0,10'd5,16'h0010,16'h0500,10'd0,10'd0,1'b0,1'b1,1'b0});
        vq.push_back('{1'b0,1'b0,1'b0,1'b0,1'b0,16'h0000,10'd0,10'd0,16'h0000,16'h0500,10'd0,10'd0,1'b0,1'b0,1'b0});
        // abort by reg_load
        vq.push_back('{1'b0,1'b0,1'b0,1'b1,1'b0,16'h4000,10'd4,10'd3,16'h0100,16'h4000,10'd0,10'd0,1'b1,1'b0,1'b0});
        vq.push_back('{1'b0,1'b0,1'b0,1'b0,1'b1,16'h0000,10'd0,10'd0,16'h0000,16'h4001,10'd1,10'd0,1'b1,1'b0,1'b0});
        vq.push_back('{1'b1,1'b0,1'b0,1'b0,1'b1,16'h2000,10'd0,10'd0,16'h0000,16'h2000,10'd1,10'd0,1'b0,1'b0,1'b0});
        vq.push_back('{1'b0,1'b0,1'b0,1'b0,1'b1,16'h0000,10'd0,10'd0,16'h0000,16'h2000,10'd1,10'd0,1'b0,1'b0,1'b0});
        // restart by scan_start mid-scan
        vq.push_back('{1'b0,1'b0,1'b0,1'b1,1'b0,16'h5000,10'd2,10'd2,16'h0010,16'h5000,10'd0,10'd0,1'b1,1'b0,1'b0});
        vq.push_back('{1'b0,1'b0,1'b0,1'b0,1'b1,16'h0000,10'd0,10'd0,16'h0000,16'h5001,10'd1,10'd0,1'b1,1'b0,1'b1});
        vq.push_back('{1'b0,1'b0,1'b0,1'b0,1'b1,16'h0000,10'd0,10'd0,16'h0000,16'h5010,10'd0,10'd1,1'b1,1'b0,1'b0});
        vq.push_back('{1'b0,1'b0,1'b0,1'b1,1'b1,16'h3000,10'd2,10'd2,16'h0010,16'h3000,10'd0,10'd0,1'b1,1'b0,1'b0});
        vq.push_back('{1'b0,1'b0,1'b0,1'b0,1'b1,16'h0000,10'd0,10'd0,16'h0000,16'h3001,10'd1,10'd0,1'b1,1'b0,1'b1});
        // gated stepping with wrap, reg_inc/reg_dec ignored while scanning
        vq.push_back('{1'b0,1'b0,1'b0,1'b1,1'b0,16'hFFFE,10'd4,10'd1,16'h0000,16'hFFFE,10'd0,10'd0,1'b1,1'b0,1'b0});
        vq.push_back('{1'b0,1'b1,1'b0,1'b0,1'b0,16'h0000,10'd0,10'd0,16'h0000,16'hFFFE,10'd0,10'd0,1'b1,1'b0,1'b0});
        vq.push_back('{1'b0,1'b0,1'b0,1'b0,1'b1,16'h0000,10'd0,10'd0,16'h0000,16'hFFFF,10'd1,10'd0,1'b1,1'b0,1'b0});
        vq.push_back('{1'b0,1'b1,1'b0,1'b0,1'b0,16'h0000,10'd0,10'd0,16'h0000,16'hFFFF,10'd1,10'd0,1'b1,1'b0,1'b0});
        vq.push_back('{1'b0,1'b0,1'b0,1'b0,1'b1,16'h0000,10'd0,10'd0,16'h0000,16'h0000,10'd2,10'd0,1'b1,1'b0,1'b0});
        vq.push_back('{1'b0,1'b0,1'b1,1'b0,1'b0,16'h0000,10'd0,10'd0,16'h0000,16'h0000,10'd2,10'd0,1'b1,1'b0,1'b0});
        vq.push_back('{1'b0,1'b0,1'b0,1'b0,1'b1,16'h0000,10'd0,10'd0,16'h0000,16'h0001,10'd3,10'd0,1'b1,1'b0,1'b1});
        vq.push_back('{1'b0,1'b1,1'b0,1'b0,1'b0,16'h0000,10'd0,10'd0,16'h0000,16'h0001,10'd3,10'd0,1'b1,1'b0,1'b1});
        vq.push_back('{1'b0,1'b0,1'b0,1'b0,1'b1,16'h0000,10'd0,10'd0,16'h0000,16'h0001,10'd3,10'd0,1'b0,1'b1,1'b0});
        // new scan accepted while scan_done is high; 1x1 scan
        vq.push_back('{1'b0,1'b0,1'b0,1'b1,1'b0,16'h0100,10'd1,10'd1,16'h0000,16'h0100,10'd0,10'd0,1'b1,1'b0,1'b1});
        vq.push_back('{1'b0,1'b0,1'b0,1'b0,1'b1,16'h0000,10'd0,10'd0,16'h0000,16'h0100,10'd0,10'd0,1'b0,1'b1,1'b0});

        drive(idle_v);
        Rst = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        check_all("reset", 16'h0000, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0);
        @(negedge Clk);
        Rst = 1'b0;
        @(posedge Clk);
        #1;

        foreach (vq[i]) begin
            drive(vq[i]);
            @(posedge Clk);
            #1;
            check_all($sformatf("v%0d", i), vq[i].e_addr, vq[i].e_col, vq[i].e_row,
                      vq[i].e_busy, vq[i].e_done, vq[i].e_eor);
        end

        // Asynchronous reset in the middle of a scan
        drive('{1'b0,1'b0,1'b0,1'b1,1'b0,16'h7000,10'd5,10'd5,16'h0020,16'h0,10'd0,10'd0,1'b0,1'b0,1'b0});
        @(posedge Clk);
        #1;
        drive('{1'b0,1'b0,1'b0,1'b0,1'b1,16'h0000,10'd0,10'd0,16'h0000,16'h0,10'd0,10'd0,1'b0,1'b0,1'b0});
        repeat (2) @(posedge Clk);
        #1;
        check_all("prerst", 16'h7002, 10'd2, 10'd0, 1'b1, 1'b0, 1'b0);
        #2;
        Rst = 1'b1;
        #1;
        check_all("midrst", 16'h0000, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0);
        @(negedge Clk);
        Rst = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        check_all("postrst", 16'h0000, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end
endmodule
